pcap_multi_capture: RTL and testbench

//   Parametrised position-capture core for NCHAN position-bus channels.
//   Per channel it captures VALUE, DIFF or shifted SUM on each capture edge

---
 rtl/pcap_multi_capture.sv | 272 +++++++++++++++++++++++++++
 tb/tb_pcap_multi_capture.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcap_multi_capture.sv
// Multi-channel position capture: VALUE/DIFF/SUM per channel on capture edges,
// each capture streamed out as an NCHAN-word frame on a valid/ready interface.
module pcap_multi_capture #(
    parameter int NCHAN = 4,
    parameter int DW    = 32,
    parameter int ACC_W = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  arm_i,
    input  logic                  disarm_i,
    input  logic [1:0]            capture_edge_i,
    input  logic [5:0]            shift_sum_i,
    input  logic [2*NCHAN-1:0]    chan_mode_i,
    input  logic                  enable_i,
    input  logic                  gate_i,
    input  logic                  capture_i,
    input  logic [NCHAN*DW-1:0]   posbus_i,
    output logic [DW-1:0]         dat_o,
    output logic                  dat_valid_o,
    input  logic                  dat_ready_i,
    output logic                  actv_o,
    output logic                  done_o,
    output logic [1:0]            status_o,
    output logic [1:0]            health_o
);
    localparam int            IW       = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHAN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             enable_q, enable_d, capture_q, capture_d;
    logic [DW-1:0]    prev_q [NCHAN];
    logic [DW-1:0]    prev_d [NCHAN];
    logic [ACC_W-1:0] acc_q [NCHAN];
    logic [ACC_W-1:0] acc_d [NCHAN];
    logic [DW-1:0]    shadow_q [NCHAN];
    logic [DW-1:0]    shadow_d [NCHAN];
    logic [IW-1:0]    idx_q, idx_d;
    logic [DW-1:0]    dat_q, dat_d;
    logic             dat_valid_q, dat_valid_d;
    logic             actv_q, actv_d, done_q, done_d;
    logic [1:0]       status_q, status_d, health_q, health_d, pend_q, pend_d;

    logic [DW-1:0]           sample_s   [NCHAN];
    logic [ACC_W-1:0]        sext_s     [NCHAN];
    logic [ACC_W-1:0]        sum_full_s [NCHAN];
    logic signed [ACC_W-1:0] sum_sh_s   [NCHAN];
    logic [DW-1:0]           word_s     [NCHAN];
    logic [NCHAN-1:0]        ovf_s;
    logic                    edge_s, cap_s, accept_s, frame_free_s, start_s, too_close_s;
    logic                    en_rise_s, en_fall_s, end_req_s;
    logic [1:0]              end_status_s;
    logic [IW-1:0]           nxt_idx_s;

    // Per-channel capture word; SUM includes this cycle's gated sample.
    always_comb begin
        for (int n = 0; n < NCHAN; n++) begin
            sample_s[n]   = posbus_i[n*DW +: DW];
            sext_s[n]     = {{(ACC_W-DW){sample_s[n][DW-1]}}, sample_s[n]};
            sum_full_s[n] = acc_q[n] + (gate_i ? sext_s[n] : {ACC_W{1'b0}});
            sum_sh_s[n]   = $signed(sum_full_s[n]) >>> shift_sum_i;
            ovf_s[n]      = 1'b0;
            case (chan_mode_i[2*n +: 2])
                2'd1:    word_s[n] = sample_s[n] - prev_q[n];
                2'd2: begin
                    word_s[n] = sum_sh_s[n][DW-1:0];
                    ovf_s[n]  = (sum_sh_s[n][ACC_W-1:DW-1] != {(ACC_W-DW+1){sum_sh_s[n][DW-1]}});
                end
                default: word_s[n] = sample_s[n];
            endcase
        end
    end

    // Edge detection and frame-slot arbitration.
    always_comb begin
        case (capture_edge_i)
            2'd1:    edge_s = ~capture_i & capture_q;
            2'd2:    edge_s = capture_i ^ capture_q;
            default: edge_s = capture_i & ~capture_q;
        endcase
        en_rise_s    = enable_i & ~enable_q;
        en_fall_s    = ~enable_i & enable_q;
        cap_s        = (state_q == ST_RUN) & enable_i & edge_s & ~disarm_i;
        accept_s     = dat_valid_q & dat_ready_i;
        frame_free_s = ~dat_valid_q | (accept_s & (idx_q == LAST_IDX));
        start_s      = cap_s & frame_free_s;
        too_close_s  = cap_s & ~frame_free_s;
        nxt_idx_s    = idx_q + 1'b1;
    end

    // Next-state: streaming datapath, accumulators, then acquisition FSM.
    always_comb begin
        state_d      = state_q;
        enable_d     = enable_i;
        capture_d    = capture_i;
        prev_d       = prev_q;
        acc_d        = acc_q;
        shadow_d     = shadow_q;
        idx_d        = idx_q;
        dat_d        = dat_q;
        dat_valid_d  = dat_valid_q;
        done_d       = 1'b0;
        status_d     = status_q;
        health_d     = health_q;
        pend_d       = pend_q;
        end_req_s    = 1'b0;
        end_status_s = 2'd0;

        if (accept_s) begin
            if (idx_q == LAST_IDX) begin
                dat_valid_d = 1'b0;
            end else begin
                idx_d = nxt_idx_s;
                dat_d = shadow_q[nxt_idx_s];
            end
        end else begin
            dat_valid_d = dat_valid_q;
        end

        if (start_s) begin
            for (int n = 0; n < NCHAN; n++) begin
                shadow_d[n] = word_s[n];
                if (chan_mode_i[2*n +: 2] == 2'd1) begin
                    prev_d[n] = sample_s[n];
                end else begin
                    prev_d[n] = prev_q[n];
                end
            end
            dat_valid_d = 1'b1;
            idx_d       = '0;
            dat_d       = word_s[0];
            if ((|ovf_s) && (health_q != 2'd1)) begin
                health_d = 2'd2;
            end else begin
                health_d = health_q;
            end
        end else if (too_close_s) begin
            health_d = 2'd1;
        end else begin
            health_d = health_q;
        end

        if (state_q == ST_RUN) begin
            for (int n = 0; n < NCHAN; n++) begin
                if (start_s) begin
                    acc_d[n] = '0;
                end else if (gate_i) begin
                    acc_d[n] = acc_q[n] + sext_s[n];
                end else begin
                    acc_d[n] = acc_q[n];
                end
            end
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (arm_i) begin
                    state_d  = ST_ARMED;
                    health_d = 2'd0;
                    status_d = 2'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (disarm_i) begin
                    end_req_s    = 1'b1;
                    end_status_s = 2'd1;
                end else if (en_rise_s) begin
                    state_d = ST_RUN;
                    for (int n = 0; n < NCHAN; n++) begin
                        acc_d[n]  = '0;
                        prev_d[n] = sample_s[n];
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_RUN: begin
                if (disarm_i) begin
                    end_req_s    = 1'b1;
                    end_status_s = 2'd1;
                end else if (too_close_s) begin
                    end_req_s    = 1'b1;
                    end_status_s = 2'd2;
                end else if (en_fall_s) begin
                    end_req_s    = 1'b1;
                    end_status_s = 2'd0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                end_req_s    = 1'b1;
                end_status_s = pend_q;
            end
            default: state_d = ST_IDLE;
        endcase

        // Finishing waits in DRAIN only while a frame is still being sent.
        if (end_req_s) begin
            if (dat_valid_d) begin
                state_d = ST_DRAIN;
                pend_d  = end_status_s;
            end else begin
                state_d  = ST_IDLE;
                done_d   = 1'b1;
                status_d = end_status_s;
            end
        end else begin
            pend_d = pend_q;
        end

        actv_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            enable_q    <= 1'b0;
            capture_q   <= 1'b0;
            idx_q       <= '0;
            dat_q       <= '0;
            dat_valid_q <= 1'b0;
            actv_q      <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= 2'd0;
            health_q    <= 2'd0;
            pend_q      <= 2'd0;
            for (int n = 0; n < NCHAN; n++) begin
                prev_q[n]   <= '0;
                acc_q[n]    <= '0;
                shadow_q[n] <= '0;
            end
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            capture_q   <= capture_d;
            idx_q       <= idx_d;
            dat_q       <= dat_d;
            dat_valid_q <= dat_valid_d;
            actv_q      <= actv_d;
            done_q      <= done_d;
            status_q    <= status_d;
            health_q    <= health_d;
            pend_q      <= pend_d;
            for (int n = 0; n < NCHAN; n++) begin
                prev_q[n]   <= prev_d[n];
                acc_q[n]    <= acc_d[n];
                shadow_q[n] <= shadow_d[n];
            end
        end
    end

    assign dat_o       = dat_q;
    assign dat_valid_o = dat_valid_q;
    assign actv_o      = actv_q;
    assign done_o      = done_q;
    assign status_o    = status_q;
    assign health_o    = health_q;

endmodule

// File: tb/tb_pcap_multi_capture.sv
// Scoreboard bench for pcap_multi_capture: expected frame words are queued at
// capture time and checked by a stream monitor as they are accepted.
`timescale 1ns/1ps
module tb_pcap_multi_capture;
    localparam int NCHAN = 4;
    localparam int DW    = 32;
    localparam int ACC_W = 64;

    logic                clk = 1'b0;
    logic                rst;
    logic                arm, disarm, enable, gate, capture, ready;
    logic [1:0]          cap_edge;
    logic [5:0]          shift;
    logic [2*NCHAN-1:0]  mode;
    logic [NCHAN*DW-1:0] posbus;
    logic [DW-1:0]       dat_o;
    logic                dat_valid_o, actv_o, done_o;
    logic [1:0]          status_o, health_o;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] sb [$];
    logic          last_stall = 1'b0;
    logic [DW-1:0] last_dat   = '0;

    pcap_multi_capture #(.NCHAN(NCHAN), .DW(DW), .ACC_W(ACC_W)) dut (
        .clk_i(clk), .reset_i(rst), .arm_i(arm), .disarm_i(disarm),
        .capture_edge_i(cap_edge), .shift_sum_i(shift), .chan_mode_i(mode),
        .enable_i(enable), .gate_i(gate), .capture_i(capture), .posbus_i(posbus),
        .dat_o(dat_o), .dat_valid_o(dat_valid_o), .dat_ready_i(ready),
        .actv_o(actv_o), .done_o(done_o), .status_o(status_o), .health_o(health_o)
    );

    always #5 clk = ~clk;

    // Stream monitor: pops the scoreboard on every accepted word, checks hold-while-stalled.
    always @(negedge clk) begin
        if (!rst && dat_valid_o && last_stall) begin
            n_checks++;
            if (dat_o !== last_dat) begin
                n_fail++;
                $display("FAIL stall_stable: dat_o=%h changed while stalled, required %h", dat_o, last_dat);
            end
        end
        if (!rst && dat_valid_o && ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL word_unexpected: got %h, required no word", dat_o);
            end else begin
                logic [DW-1:0] exp_w;
                exp_w = sb.pop_front();
                if (dat_o !== exp_w) begin
                    n_fail++;
                    $display("FAIL word: got %h, required %h", dat_o, exp_w);
                end
            end
        end
        last_stall = !rst && dat_valid_o && !ready;
        last_dat   = dat_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input logic [DW-1:0] a, b, c, d);
        posbus = {d, c, b, a};
    endtask

    task automatic push4(input logic [DW-1:0] a, b, c, d);
        sb.push_back(a); sb.push_back(b); sb.push_back(c); sb.push_back(d);
    endtask

    task automatic arm_seq();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic capture_pulse();
        capture = 1'b1; tick(); capture = 1'b0;
    endtask

    task automatic wait_sb_empty(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        ok = (sb.size() == 0);
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b0; disarm = 1'b0; enable = 1'b0; gate = 1'b0;
        capture = 1'b0; ready = 1'b1; cap_edge = 2'd0; shift = 6'd0; mode = '0;
        set_pos(32'd0, 32'd0, 32'd0, 32'd0);
        tick(); tick();
        n_checks++;
        if ({dat_valid_o, actv_o, done_o, status_o, health_o} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_flags: v/a/d/st/h=%b, required 0000000",
                     {dat_valid_o, actv_o, done_o, status_o, health_o});
        end
        n_checks++;
        if (dat_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_dat: dat_o=%h, required 0", dat_o);
        end
        rst = 1'b0; tick();
    endtask

    task automatic test_value();
        bit ok;
        mode = 8'h00; cap_edge = 2'd0; ready = 1'b1;
        set_pos(32'd10, 32'd20, 32'd30, 32'd40);
        arm_seq();
        n_checks++;
        if (actv_o !== 1'b1) begin n_fail++; $display("FAIL value_actv: actv_o=%b, required 1", actv_o); end
        enable = 1'b1; tick(); tick(); tick();
        push4(32'd10, 32'd20, 32'd30, 32'd40);
        capture_pulse();
        n_checks++;
        if (dat_valid_o !== 1'b1 || dat_o !== 32'd10) begin
            n_fail++; $display("FAIL value_first: valid=%b dat=%0d, required 1/10", dat_valid_o, dat_o);
        end
        tick(); tick(); tick(); tick();
        n_checks++;
        if (dat_valid_o !== 1'b0 || sb.size() != 0) begin
            n_fail++; $display("FAIL value_len: valid=%b pending=%0d, required 0/0", dat_valid_o, sb.size());
        end
        wait_sb_empty(20, ok);
        enable = 1'b0; tick();
        n_checks++;
        if (done_o !== 1'b1 || status_o !== 2'd0 || actv_o !== 1'b0) begin
            n_fail++; $display("FAIL value_done: done=%b status=%0d actv=%b, required 1/0/0", done_o, status_o, actv_o);
        end
        tick();
        n_checks++;
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL value_done_pulse: done_o=%b, required 0", done_o); end
    endtask

    task automatic test_sum();
        bit ok;
        mode = 8'b00_00_00_10; shift = 6'd1;
        set_pos(32'd6, 32'd20, 32'd30, 32'd40);
        arm_seq();
        enable = 1'b1; tick();
        gate = 1'b1; tick(); tick(); tick();
        push4(32'd12, 32'd20, 32'd30, 32'd40);
        capture = 1'b1; tick(); capture = 1'b0; gate = 1'b0;
        wait_sb_empty(20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL sum_frame1: %0d words pending, required 0", sb.size()); end
        tick(); tick();
        push4(32'd0, 32'd20, 32'd30, 32'd40);
        capture_pulse();
        wait_sb_empty(20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL sum_frame2: %0d words pending, required 0", sb.size()); end
        n_checks++;
        if (health_o !== 2'd0) begin n_fail++; $display("FAIL sum_health: health_o=%0d, required 0", health_o); end
        enable = 1'b0; tick();
        n_checks++;
        if (done_o !== 1'b1 || status_o !== 2'd0) begin
            n_fail++; $display("FAIL sum_done: done=%b status=%0d, required 1/0", done_o, status_o);
        end
        shift = 6'd0;
    endtask

    task automatic test_diff();
        bit ok;
        mode = 8'b00_00_00_01;
        set_pos(32'd100, 32'd1, 32'd2, 32'd3);
        arm_seq();
        enable = 1'b1; tick(); tick();
        set_pos(32'd250, 32'd1, 32'd2, 32'd3);
        push4(32'd150, 32'd1, 32'd2, 32'd3);
        capture_pulse();
        wait_sb_empty(20, ok);
        set_pos(32'd240, 32'd1, 32'd2, 32'd3);
        push4(32'hFFFF_FFF6, 32'd1, 32'd2, 32'd3);
        capture_pulse();
        wait_sb_empty(20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL diff_frames: %0d words pending, required 0", sb.size()); end
        enable = 1'b0; tick(); tick();
    endtask

    task automatic test_too_close();
        bit found;
        mode = 8'h00; ready = 1'b0;
        set_pos(32'd1, 32'd2, 32'd3, 32'd4);
        arm_seq();
        enable = 1'b1; tick(); tick();
        push4(32'd1, 32'd2, 32'd3, 32'd4);
        capture_pulse();
        set_pos(32'd5, 32'd6, 32'd7, 32'd8);
        n_checks++;
        if (dat_valid_o !== 1'b1 || dat_o !== 32'd1) begin
            n_fail++; $display("FAIL close_first: valid=%b dat=%0d, required 1/1", dat_valid_o, dat_o);
        end
        tick(); tick(); tick();
        capture_pulse();
        n_checks++;
        if (health_o !== 2'd1 || status_o !== 2'd0 || actv_o !== 1'b1) begin
            n_fail++; $display("FAIL close_flag: health=%0d status=%0d actv=%b, required 1/0/1", health_o, status_o, actv_o);
        end
        tick();
        ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done_o === 1'b1) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found || sb.size() != 0) begin
            n_fail++; $display("FAIL close_done: done_seen=%b pending=%0d, required 1/0", found, sb.size());
        end
        n_checks++;
        if (status_o !== 2'd2 || health_o !== 2'd1 || actv_o !== 1'b0) begin
            n_fail++; $display("FAIL close_status: status=%0d health=%0d actv=%b, required 2/1/0", status_o, health_o, actv_o);
        end
        enable = 1'b0; tick(); tick();
    endtask

    task automatic test_disarm();
        set_pos(32'd1, 32'd2, 32'd3, 32'd4);
        arm_seq();
        n_checks++;
        if (health_o !== 2'd0 || status_o !== 2'd0) begin
            n_fail++; $display("FAIL arm_clear: health=%0d status=%0d, required 0/0", health_o, status_o);
        end
        enable = 1'b1; tick(); tick();
        disarm = 1'b1; capture = 1'b1; tick(); disarm = 1'b0; capture = 1'b0;
        n_checks++;
        if (done_o !== 1'b1 || status_o !== 2'd1 || actv_o !== 1'b0 || dat_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL disarm_done: done=%b status=%0d actv=%b valid=%b, required 1/1/0/0",
                               done_o, status_o, actv_o, dat_valid_o);
        end
        tick();
        n_checks++;
        if (done_o !== 1'b0 || dat_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL disarm_after: done=%b valid=%b, required 0/0", done_o, dat_valid_o);
        end
        enable = 1'b0; tick();
    endtask

    task automatic test_both_edges();
        bit ok;
        logic [DW-1:0] base;
        mode = 8'h00; cap_edge = 2'd2;
        arm_seq();
        enable = 1'b1; tick(); tick();
        for (int k = 0; k < 3; k++) begin
            base = 32'd100 * (k + 1);
            set_pos(base, base + 32'd1, base + 32'd2, base + 32'd3);
            push4(base, base + 32'd1, base + 32'd2, base + 32'd3);
            capture = ~capture; tick();
            n_checks++;
            if (dat_valid_o !== 1'b1) begin n_fail++; $display("FAIL both_edge%0d: valid=%b, required 1", k, dat_valid_o); end
            wait_sb_empty(20, ok);
            tick(); tick();
        end
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL both_frames: %0d pending, required 0", sb.size()); end
        enable = 1'b0; tick(); tick();
        capture = 1'b0; tick();
        cap_edge = 2'd0; mode = 8'b00_00_00_10; shift = 6'd0;
        set_pos(32'h4000_0000, 32'd1, 32'd2, 32'd3);
        arm_seq();
        enable = 1'b1; tick();
        gate = 1'b1; tick(); tick(); tick();
        push4(32'd0, 32'd1, 32'd2, 32'd3);
        capture = 1'b1; tick(); capture = 1'b0; gate = 1'b0;
        n_checks++;
        if (health_o !== 2'd2) begin n_fail++; $display("FAIL sum_ovf: health_o=%0d, required 2", health_o); end
        wait_sb_empty(20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ovf_frame: %0d words pending, required 0", sb.size()); end
        enable = 1'b0; tick();
        n_checks++;
        if (done_o !== 1'b1 || health_o !== 2'd2) begin
            n_fail++; $display("FAIL ovf_sticky: done=%b health=%0d, required 1/2", done_o, health_o);
        end
        tick();
    endtask

    task automatic test_reset_midframe();
        mode = 8'h00; ready = 1'b0;
        set_pos(32'd7, 32'd8, 32'd9, 32'd10);
        arm_seq();
        enable = 1'b1; tick(); tick();
        capture_pulse();
        rst = 1'b1; #1;
        sb.delete();
        n_checks++;
        if (dat_valid_o !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: valid=%b, required 0", dat_valid_o); end
        enable = 1'b0; tick(); tick();
        n_checks++;
        if (done_o !== 1'b0 || actv_o !== 1'b0) begin
            n_fail++; $display("FAIL midreset_done: done=%b actv=%b, required 0/0", done_o, actv_o);
        end
        rst = 1'b0; ready = 1'b1; tick();
    endtask

    initial begin
        test_reset();
        test_value();
        test_sum();
        test_diff();
        test_too_close();
        test_disarm();
        test_both_edges();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
